// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state type, default constants and counter width helper
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  localparam int CLOCKS_PER_PULSE_DEF = 4;
  localparam int BITS_PER_WORD_DEF    = 8;

  // Counter width for a count range of n, never below 1 so n=1 still yields a legal vector
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - bit period counter flagging the last clock of each period
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = CLOCKS_PER_PULSE_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int CW = cnt_width(CLOCKS_PER_PULSE);
  localparam logic [CW-1:0] LAST_VAL = CW'(CLOCKS_PER_PULSE - 1);

  logic [CW-1:0] cnt;

  // Free-running period counter while enabled, wrapping at the end of each bit period
  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST_VAL) ? '0 : cnt + 1'b1;
    end
  end

  assign last = (cnt == LAST_VAL);

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter sending one W_IN-bit word as NUM_WORDS frames
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = CLOCKS_PER_PULSE_DEF,
  parameter int BITS_PER_WORD    = BITS_PER_WORD_DEF,
  parameter int W_IN             = 24
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [W_IN-1:0] s_data,
  output logic            tx
);

  localparam int NUM_WORDS = W_IN / BITS_PER_WORD;
  localparam int BIT_W     = cnt_width(BITS_PER_WORD);
  localparam int WORD_W    = cnt_width(NUM_WORDS);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BITS_PER_WORD - 1);
  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(NUM_WORDS - 1);

  uart_state_t       state;
  logic [W_IN-1:0]   shift;
  logic [BIT_W-1:0]  c_bits;
  logic [WORD_W-1:0] c_words;
  logic              baud_clr;
  logic              baud_en;
  logic              baud_last;

  // The period counter is held at zero in IDLE so the start bit begins a full period after the handshake
  assign baud_clr = (state == IDLE);
  assign baud_en  = (state != IDLE);

  uart_baud_cnt #(
    .CLOCKS_PER_PULSE(CLOCKS_PER_PULSE)
  ) u_baud (
    .clk  (clk),
    .rstn (rstn),
    .clr  (baud_clr),
    .en   (baud_en),
    .last (baud_last)
  );

  // Frame sequencer: line, ready, shift register and bit/word counters all registered here
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      tx      <= 1'b1;
      s_ready <= 1'b1;
      shift   <= '0;
      c_bits  <= '0;
      c_words <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s_valid && s_ready) begin
            shift   <= s_data;
            s_ready <= 1'b0;
            tx      <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (baud_last) begin
            tx    <= ~shift[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (baud_last) begin
            // Shifting right keeps the next word's LSB in shift[0] once this word is done
            shift <= shift >> 1;
            if (c_bits == BIT_LAST) begin
              c_bits <= '0;
              tx     <= 1'b1;
              state  <= STOP;
            end else begin
              c_bits <= c_bits + 1'b1;
              tx     <= ~shift[1];
            end
          end
        end
        STOP: begin
          if (baud_last) begin
            if (c_words == WORD_LAST) begin
              c_words <= '0;
              s_ready <= 1'b1;
              state   <= IDLE;
            end else begin
              c_words <= c_words + 1'b1;
              tx      <= 1'b0;
              state   <= START;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx
module tb_uart_tx;

  localparam int CPP = 4;
  localparam int BPW = 8;
  localparam int NW  = 3;
  localparam int FL  = (BPW + 2) * CPP;
  localparam int XL  = NW * FL;

  logic        clk = 1'b0;
  logic        rstn;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] s_data;
  logic        tx;
  logic        c_valid;
  logic        c_ready;
  logic [7:0]  c_data;
  logic        c_tx;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_tx dut (
    .clk     (clk),
    .rstn    (rstn),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .tx      (tx)
  );

  uart_tx #(
    .CLOCKS_PER_PULSE(2),
    .BITS_PER_WORD   (8),
    .W_IN            (8)
  ) dut_c (
    .clk     (clk),
    .rstn    (rstn),
    .s_valid (c_valid),
    .s_ready (c_ready),
    .s_data  (c_data),
    .tx      (c_tx)
  );

  typedef struct {
    logic [23:0] word;
    logic [9:0]  frame0;
  } vec_t;

  vec_t tbl[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected line level k cycles after the handshake edge, from frame arithmetic
  function automatic logic model_line(input logic [23:0] w, input int k);
    int f;
    int p;
    if (k >= XL) return 1'b1;
    f = k / FL;
    p = (k % FL) / CPP;
    if (p == 0) return 1'b0;
    if (p <= BPW) return ~w[f*BPW + p - 1];
    return 1'b1;
  endfunction

  function automatic logic [9:0] frame0_model(input logic [23:0] w);
    return {1'b1, ~w[7:0], 1'b0};
  endfunction

  // Caller has s_valid=1 and s_data=word applied at a negedge; the handshake is the next posedge
  task automatic run_xfer(input logic [23:0] word, input logic [9:0] exp_f0,
                          input bit b2b, input logic [23:0] nxt, input bit poke);
    logic        line[XL+1];
    int          low;
    int          mis;
    logic        rdy_end;
    logic [23:0] got;
    logic [9:0]  f0;
    check("ready_before", s_ready, 1);
    @(posedge clk);
    low = 0;
    rdy_end = 1'b0;
    for (int k = 0; k <= XL; k++) begin
      @(negedge clk);
      line[k] = tx;
      if (k < XL && !s_ready) low++;
      if (k == XL) rdy_end = s_ready;
      if (k == 0 && !b2b) s_valid = 1'b0;
      if (poke && k >= 50 && k < 60) begin
        s_data  = 24'hDEADBE;
        s_valid = (k % 2 == 1);
      end
      if (poke && k == 60) s_valid = 1'b0;
      if (k == XL && b2b) s_data = nxt;
    end
    check("ready_low_cycles", low, XL);
    check("ready_return", rdy_end, 1);
    mis = 0;
    for (int k = 0; k <= XL; k++) if (line[k] !== model_line(word, k)) mis++;
    check("line_wave_mismatches", mis, 0);
    for (int f = 0; f < NW; f++)
      for (int j = 0; j < BPW; j++)
        got[f*BPW + j] = ~line[f*FL + (1 + j)*CPP + CPP/2];
    check("loopback_word", got, word);
    for (int b = 0; b < 10; b++) f0[b] = line[b*CPP + CPP/2];
    check("first_frame", f0, exp_f0);
  endtask

  task automatic start(input logic [23:0] word);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = word;
  endtask

  initial begin
    logic [23:0] w;
    logic [9:0]  cv;
    logic        cl[21];
    int          low;
    int          mis;
    int          bad_idle;
    logic        crdy;

    tbl[0] = '{24'hA53C01, 10'h3FC};
    tbl[1] = '{24'h000000, 10'h3FE};
    tbl[2] = '{24'hFFFFFF, 10'h200};

    rstn = 1'b0; s_valid = 1'b0; s_data = '0; c_valid = 1'b0; c_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_ready", s_ready, 1);
    check("reset_c_tx", c_tx, 1);
    check("reset_c_ready", c_ready, 1);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven single transfers
    for (int i = 0; i < 3; i++) begin
      start(tbl[i].word);
      run_xfer(tbl[i].word, tbl[i].frame0, 1'b0, '0, 1'b0);
    end

    // Back-to-back with s_valid held across the boundary
    start(24'h123456);
    run_xfer(24'h123456, 10'h352, 1'b1, 24'h654321, 1'b0);
    run_xfer(24'h654321, 10'h3BC, 1'b0, '0, 1'b0);

    // Busy ignore, then confirm no extra transfer starts
    start(24'hA53C01);
    run_xfer(24'hA53C01, 10'h3FC, 1'b0, '0, 1'b1);
    bad_idle = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (tx !== 1'b1 || s_ready !== 1'b1) bad_idle++;
    end
    check("busy_no_extra_xfer", bad_idle, 0);

    // Reset during DATA of word 2
    start(24'h5A5A5A);
    @(posedge clk);
    for (int k = 0; k <= 50; k++) begin
      @(negedge clk);
      if (k == 0) s_valid = 1'b0;
    end
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    check("midreset_tx", tx, 1);
    check("midreset_ready", s_ready, 1);
    repeat (3) @(negedge clk);
    start(24'h0F0F0F);
    run_xfer(24'h0F0F0F, 10'h3E0, 1'b0, '0, 1'b0);

    // Randomized transfers against the frame model
    for (int i = 0; i < 5; i++) begin
      w = 24'($urandom);
      start(w);
      run_xfer(w, frame0_model(w), 1'b0, '0, 1'b0);
    end

    // Parameter corner: 2 clocks per bit, single 8-bit word 0x80
    cv = 10'h2FE;
    @(negedge clk);
    c_valid = 1'b1;
    c_data  = 8'h80;
    @(posedge clk);
    low  = 0;
    crdy = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      cl[k] = c_tx;
      if (k == 0) c_valid = 1'b0;
      if (k < 20 && !c_ready) low++;
      if (k == 20) crdy = c_ready;
    end
    check("corner_ready_low", low, 20);
    check("corner_ready_return", crdy, 1);
    mis = 0;
    for (int k = 0; k < 20; k++) if (cl[k] !== cv[k/2]) mis++;
    if (cl[20] !== 1'b1) mis++;
    check("corner_wave_mismatches", mis, 0);
    check("corner_msb_line", cl[17], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
